// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter and its dump sequencer.
package dmem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DUMP_REQ  = 3'd1,
    DUMP_WAIT = 3'd2,
    DUMP_HOLD = 3'd3,
    DONE      = 3'd4
  } dump_state_t;

  // Byte lanes per RAM word.
  function automatic int unsigned col_count(input int unsigned nb_reg);
    return nb_reg / 8;
  endfunction

  // Byte address of the final RAM word visited by a dump.
  function automatic int unsigned last_word_addr(input int unsigned ram_depth,
                                                 input int unsigned nb_col);
    return (ram_depth - 1) * nb_col;
  endfunction

endpackage

// File: rtl/dmem_dump_seq.sv
// Dump sequencer: walks every RAM word in order and streams it out over valid/ready,
// yielding the RAM port to the pipeline whenever it requests it.
module dmem_dump_seq
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned NB_REG    = 32,
  parameter int unsigned NB_ADDR   = 32,
  parameter int unsigned NB_COL    = col_count(NB_REG),
  parameter int unsigned RAM_DEPTH = 1024
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_pipe_req,
  input  logic               i_dbg_start,
  input  logic               i_dbg_ready,
  input  logic [NB_REG-1:0]  i_ram_dout,
  output logic               o_dump_read,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic               o_dbg_valid,
  output logic [NB_REG-1:0]  o_dbg_data,
  output logic [NB_ADDR-1:0] o_dbg_addr,
  output logic               o_dbg_busy,
  output logic               o_dbg_done
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(last_word_addr(RAM_DEPTH, NB_COL));
  localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(NB_COL);

  dump_state_t        state;
  dump_state_t        next_state;
  logic [NB_ADDR-1:0] dump_addr;
  logic               launch;
  logic               capture;
  logic               accept;
  logic               is_last;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      dump_addr   <= '0;
      o_dbg_valid <= 1'b0;
      o_dbg_data  <= '0;
      o_dbg_addr  <= '0;
      o_dbg_busy  <= 1'b0;
      o_dbg_done  <= 1'b0;
    end else begin
      state      <= next_state;
      o_dbg_done <= accept && is_last;
      if (launch) begin
        dump_addr  <= '0;
        o_dbg_busy <= 1'b1;
      end
      if (capture) begin
        o_dbg_data  <= i_ram_dout;
        o_dbg_addr  <= dump_addr;
        o_dbg_valid <= 1'b1;
      end
      if (accept) begin
        o_dbg_valid <= 1'b0;
        if (is_last) begin
          o_dbg_busy <= 1'b0;
        end else begin
          dump_addr <= dump_addr + ADDR_STEP;
        end
      end
    end
  end

  // Final word found by compare so a full-width address never relies on wrap-around.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (i_dbg_start) next_state = DUMP_REQ;
      DUMP_REQ:  if (!i_pipe_req) next_state = DUMP_WAIT;
      DUMP_WAIT: next_state = DUMP_HOLD;
      DUMP_HOLD: if (i_dbg_ready) next_state = is_last ? DONE : DUMP_REQ;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    is_last     = (dump_addr == LAST_ADDR);
    launch      = (state == IDLE) && i_dbg_start;
    o_dump_read = (state == DUMP_REQ) && !i_pipe_req;
    capture     = (state == DUMP_WAIT);
    accept      = (state == DUMP_HOLD) && i_dbg_ready;
    o_dump_addr = dump_addr;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data RAM port between the pipeline MEM stage (fixed priority, never stalled)
// and the debug memory-dump engine.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned NB_REG    = 32,
  parameter int unsigned NB_ADDR   = 32,
  parameter int unsigned NB_COL    = col_count(NB_REG),
  parameter int unsigned RAM_DEPTH = 1024
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_pipe_re,
  input  logic [NB_COL-1:0]  i_pipe_we,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_REG-1:0]  i_pipe_data,
  output logic [NB_REG-1:0]  o_pipe_rdata,
  input  logic               i_dbg_start,
  input  logic               i_dbg_ready,
  output logic               o_dbg_valid,
  output logic [NB_REG-1:0]  o_dbg_data,
  output logic [NB_ADDR-1:0] o_dbg_addr,
  output logic               o_dbg_busy,
  output logic               o_dbg_done,
  output logic               o_ram_en,
  output logic [NB_COL-1:0]  o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_REG-1:0]  o_ram_din,
  input  logic [NB_REG-1:0]  i_ram_dout
);

  logic               pipe_req;
  logic               dump_read;
  logic [NB_ADDR-1:0] dump_addr;

  assign pipe_req     = i_pipe_re | (|i_pipe_we);
  assign o_pipe_rdata = i_ram_dout;

  dmem_dump_seq #(
    .NB_REG   (NB_REG),
    .NB_ADDR  (NB_ADDR),
    .NB_COL   (NB_COL),
    .RAM_DEPTH(RAM_DEPTH)
  ) u_dump_seq (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_pipe_req (pipe_req),
    .i_dbg_start(i_dbg_start),
    .i_dbg_ready(i_dbg_ready),
    .i_ram_dout (i_ram_dout),
    .o_dump_read(dump_read),
    .o_dump_addr(dump_addr),
    .o_dbg_valid(o_dbg_valid),
    .o_dbg_data (o_dbg_data),
    .o_dbg_addr (o_dbg_addr),
    .o_dbg_busy (o_dbg_busy),
    .o_dbg_done (o_dbg_done)
  );

  always_comb begin
    if (dump_read) begin
      o_ram_en   = 1'b1;
      o_ram_we   = '0;
      o_ram_addr = dump_addr;
      o_ram_din  = '0;
    end else begin
      o_ram_en   = pipe_req;
      o_ram_we   = i_pipe_we;
      o_ram_addr = i_pipe_addr;
      o_ram_din  = i_pipe_data;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a small dump depth and a behavioural RAM.
module tb_dmem_port_arbiter;

  localparam int DEPTH = 4;
  localparam int WORDS = 16;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pipe_re = 1'b0;
  logic [3:0]  i_pipe_we = '0;
  logic [31:0] i_pipe_addr = '0;
  logic [31:0] i_pipe_data = '0;
  logic [31:0] o_pipe_rdata;
  logic        i_dbg_start = 1'b0;
  logic        i_dbg_ready = 1'b0;
  logic        o_dbg_valid;
  logic [31:0] o_dbg_data;
  logic [31:0] o_dbg_addr;
  logic        o_dbg_busy;
  logic        o_dbg_done;
  logic        o_ram_en;
  logic [3:0]  o_ram_we;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_din;
  logic [31:0] i_ram_dout = '0;

  dmem_port_arbiter #(
    .NB_REG   (32),
    .NB_ADDR  (32),
    .NB_COL   (4),
    .RAM_DEPTH(DEPTH)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_pipe_re  (i_pipe_re),
    .i_pipe_we  (i_pipe_we),
    .i_pipe_addr(i_pipe_addr),
    .i_pipe_data(i_pipe_data),
    .o_pipe_rdata(o_pipe_rdata),
    .i_dbg_start(i_dbg_start),
    .i_dbg_ready(i_dbg_ready),
    .o_dbg_valid(o_dbg_valid),
    .o_dbg_data (o_dbg_data),
    .o_dbg_addr (o_dbg_addr),
    .o_dbg_busy (o_dbg_busy),
    .o_dbg_done (o_dbg_done),
    .o_ram_en   (o_ram_en),
    .o_ram_we   (o_ram_we),
    .o_ram_addr (o_ram_addr),
    .o_ram_din  (o_ram_din),
    .i_ram_dout (i_ram_dout)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  // RAM behaviour: byte-enabled write, read data one cycle after the enabled access.
  logic [31:0] mem    [WORDS];
  logic [31:0] shadow [WORDS];
  always @(posedge i_clock) begin
    if (o_ram_en) begin
      i_ram_dout <= mem[o_ram_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (o_ram_we[b]) mem[o_ram_addr[5:2]][8*b +: 8] <= o_ram_din[8*b +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] rd_q  [$];
  logic [31:0] acc_q [$];
  int          done_pend      = 0;
  int          done_count     = 0;
  int          done_cyc       = 0;
  int          accepted_words = 0;
  int          first_rise     = -1;

  // Monitor: checks every cycle on the falling edge, decoupled from stimulus.
  initial begin
    logic        pr_last;
    logic [31:0] pr_exp;
    logic        prev_hold;
    logic        prev_valid;
    logic [31:0] prev_data;
    logic [31:0] prev_addr;
    logic        preq;
    pr_last = 0; prev_hold = 0; prev_valid = 0; prev_data = '0; prev_addr = '0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        pr_last = 0; prev_hold = 0; prev_valid = 0;
      end else begin
        if (pr_last) check("pipe_rdata", o_pipe_rdata, pr_exp);
        pr_last = 0;
        preq = i_pipe_re | (|i_pipe_we);
        if (preq) begin
          check("pipe_ram_en", {31'd0, o_ram_en}, 32'd1);
          check("pipe_ram_addr", o_ram_addr, i_pipe_addr);
          check("pipe_ram_we", {28'd0, o_ram_we}, {28'd0, i_pipe_we});
          if (|i_pipe_we) check("pipe_ram_din", o_ram_din, i_pipe_data);
          if (i_pipe_re) begin
            pr_last = 1;
            pr_exp  = shadow[i_pipe_addr[5:2]];
          end
          for (int b = 0; b < 4; b++)
            if (i_pipe_we[b]) shadow[i_pipe_addr[5:2]][8*b +: 8] = i_pipe_data[8*b +: 8];
        end else if (o_ram_en) begin
          if (rd_q.size() == 0) check("spurious_dump_read", o_ram_addr, 32'hFFFF_FFFF);
          else check("dump_read_addr", o_ram_addr, rd_q.pop_front());
          check("dump_read_we", {28'd0, o_ram_we}, 32'd0);
        end
        if (prev_hold) begin
          check("hold_valid", {31'd0, o_dbg_valid}, 32'd1);
          check("hold_data", o_dbg_data, prev_data);
          check("hold_addr", o_dbg_addr, prev_addr);
        end
        if (o_dbg_valid && !prev_valid && first_rise < 0) first_rise = cyc;
        if (o_dbg_valid && i_dbg_ready) begin
          if (acc_q.size() == 0) check("spurious_word", o_dbg_addr, 32'hFFFF_FFFF);
          else check("word_addr", o_dbg_addr, acc_q.pop_front());
          check("word_data", o_dbg_data, shadow[o_dbg_addr[5:2]]);
          accepted_words++;
        end
        prev_hold  = o_dbg_valid && !i_dbg_ready;
        prev_valid = o_dbg_valid;
        prev_data  = o_dbg_data;
        prev_addr  = o_dbg_addr;
        if (o_dbg_done) begin
          if (done_pend == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            done_pend--;
            check("done_words_left", acc_q.size(), 32'd0);
            check("busy_with_done", {31'd0, o_dbg_busy}, 32'd0);
          end
          done_count++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle_pipe();
    i_pipe_re = 0; i_pipe_we = '0; i_pipe_addr = '0; i_pipe_data = '0;
  endtask

  int start_cyc;
  task automatic start_dump();
    i_dbg_start = 1;
    start_cyc   = cyc;
    first_rise  = -1;
    for (int k = 0; k < DEPTH; k++) begin
      rd_q.push_back(32'(4 * k));
      acc_q.push_back(32'(4 * k));
    end
    done_pend++;
    tick();
    i_dbg_start = 0;
  endtask

  task automatic wait_done(input int limit);
    int dc0;
    int n;
    dc0 = done_count;
    n = 0;
    while (done_count == dc0 && n < limit) begin
      tick();
      n++;
    end
    if (done_count == dc0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!o_dbg_valid && n < limit) begin
      tick();
      n++;
    end
    if (!o_dbg_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;
    for (int w = 0; w < WORDS; w++) begin
      mem[w]    = (w < DEPTH) ? 32'(32'hA0 + w) : $urandom;
      shadow[w] = mem[w];
    end
    idle_pipe();
    tick(); tick();
    i_reset = 0;
    check("rst_valid", {31'd0, o_dbg_valid}, 32'd0);
    check("rst_data", o_dbg_data, 32'd0);
    check("rst_addr", o_dbg_addr, 32'd0);
    check("rst_busy", {31'd0, o_dbg_busy}, 32'd0);
    check("rst_done", {31'd0, o_dbg_done}, 32'd0);
    check("rst_ram_en", {31'd0, o_ram_en}, 32'd0);
    tick();

    // Full dump, ready high, no traffic.
    i_dbg_ready = 1;
    start_dump();
    check("busy_after_start", {31'd0, o_dbg_busy}, 32'd1);
    wait_done(100);
    check("dump_latency", 32'(done_cyc - start_cyc), 32'd13);
    check("first_word_cycle", 32'(first_rise - start_cyc), 32'd3);
    check("words_accepted", 32'(accepted_words), 32'd4);
    tick(); tick();

    // Pipeline reads hold off the dump for five cycles.
    start_dump();
    i_pipe_re = 1; i_pipe_addr = 32'h20;
    repeat (5) tick();
    idle_pipe();
    wait_done(100);
    check("yield_first_word", 32'(first_rise - start_cyc), 32'd8);
    tick(); tick();

    // Sink stalls ten cycles; start pulses while busy must be ignored.
    i_dbg_ready = 0;
    start_dump();
    wait_valid(50);
    i_dbg_start = 1; tick(); i_dbg_start = 0;
    repeat (9) tick();
    a0 = accepted_words;
    i_dbg_ready = 1; tick(); i_dbg_ready = 0;
    repeat (4) tick();
    check("one_word_advance", 32'(accepted_words), 32'(a0 + 1));
    wait_valid(50);
    check("next_word_addr", o_dbg_addr, 32'd4);
    i_dbg_ready = 1;
    wait_done(200);
    tick(); tick();

    // Byte write into word 1 during the WAIT cycle of word 0.
    start_dump();
    tick();
    i_pipe_we = 4'b0010; i_pipe_addr = 32'h4; i_pipe_data = 32'h0000_5500;
    tick();
    idle_pipe();
    n = 0;
    while (!o_dbg_done && n < 100) begin
      tick();
      n++;
    end
    check("done_seen", {31'd0, o_dbg_done}, 32'd1);
    check("word1_merged", shadow[1], 32'h0000_55A1);
    i_dbg_start = 1; tick(); i_dbg_start = 0;
    check("no_restart_from_done", {31'd0, o_dbg_busy}, 32'd0);
    repeat (5) tick();
    check("still_idle", {31'd0, o_dbg_busy}, 32'd0);

    // Reset while a word is held.
    i_dbg_ready = 0;
    start_dump();
    wait_valid(50);
    i_reset = 1;
    tick();
    i_reset = 0;
    rd_q.delete(); acc_q.delete(); done_pend = 0;
    check("abort_busy", {31'd0, o_dbg_busy}, 32'd0);
    check("abort_valid", {31'd0, o_dbg_valid}, 32'd0);
    repeat (16) tick();
    i_pipe_we = 4'hF; i_pipe_addr = 32'h10; i_pipe_data = 32'hDEAD_BEEF;
    #1;
    check("post_reset_we", {28'd0, o_ram_we}, 32'hF);
    check("post_reset_addr", o_ram_addr, 32'h10);
    tick();
    idle_pipe();
    tick();

    // Randomised traffic and back-pressure across several dumps.
    for (int d = 0; d < 6; d++) begin
      int dc0;
      int m;
      start_dump();
      dc0 = done_count;
      m = 0;
      while (done_count == dc0 && m < 600) begin
        case ($urandom_range(0, 3))
          0: begin
            i_pipe_re = 1; i_pipe_we = '0;
            i_pipe_addr = 32'($urandom_range(0, WORDS - 1) * 4);
          end
          1: begin
            i_pipe_re = 0; i_pipe_we = 4'($urandom_range(1, 15));
            i_pipe_addr = 32'($urandom_range(DEPTH, WORDS - 1) * 4);
            i_pipe_data = $urandom;
          end
          default: idle_pipe();
        endcase
        i_dbg_ready = ($urandom_range(0, 9) < 6);
        i_dbg_start = ($urandom_range(0, 15) == 0);
        tick();
        m++;
      end
      idle_pipe();
      i_dbg_start = 0;
      if (done_count == dc0) check("rand_done_timeout", 32'd0, 32'd1);
      tick(); tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
